// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: op encoding, default size, command record.
package shift_pkg;
  localparam int DEFAULT_N = 3;
  localparam int DEFAULT_W = 2 ** DEFAULT_N;

  typedef enum logic [1:0] {
    OP_SLL      = 2'b00,
    OP_SRL      = 2'b01,
    OP_PASS_ROT = 2'b10,
    OP_SRA      = 2'b11
  } shift_op_e;

  typedef struct packed {
    logic [DEFAULT_W-1:0] a;
    logic [DEFAULT_N-1:0] sh;
    shift_op_e            f;
  } shift_cmd_t;
endpackage

// File: rtl/shift_core.sv
// Combinational W-bit shifter. Op 10 is rotate-left when SHIFT_ROTATE_EN is
// defined, otherwise a plain pass-through.
module shift_core
  import shift_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int W = 2 ** N
) (
  input  logic [W-1:0] a,
  input  logic [N-1:0] sh,
  input  logic [1:0]   f,
  output logic [W-1:0] y
);

`ifdef SHIFT_ROTATE_EN
  // Shifting a doubled copy left leaves the rotated word in the upper half.
  logic [2*W-1:0] rot_dbl;
  always_comb rot_dbl = {a, a} << sh;
`endif

  always_comb begin
    y = a;
    case (shift_op_e'(f))
      OP_SLL: y = a << sh;
      OP_SRL: y = a >> sh;
      OP_SRA: y = $signed(a) >>> sh;
`ifdef SHIFT_ROTATE_EN
      OP_PASS_ROT: y = rot_dbl[2*W-1:W];
`else
      OP_PASS_ROT: y = a;
`endif
      default: y = a;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port round-robin front end sharing one shift_core, with a registered
// valid/ready result stage. SHIFT_ROTATE_EN selects rotate for op 10.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int W = 2 ** N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [N-1:0] req0_sh,
  input  logic [1:0]   req0_f,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [N-1:0] req1_sh,
  input  logic [1:0]   req1_f,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_y,
  output logic         res_src
);

  logic         last_grant_reg;
  logic         can_accept;
  logic         grant0;
  logic         grant1;
  logic         accept;
  logic         sel;
  logic [W-1:0] core_a;
  logic [N-1:0] core_sh;
  logic [1:0]   core_f;
  logic [W-1:0] core_y;

  // On contention the port that did not win last time gets the grant.
  always_comb begin
    can_accept = !res_valid || res_ready;
    grant0     = req0_valid && (!req1_valid || last_grant_reg);
    grant1     = req1_valid && (!req0_valid || !last_grant_reg);
    req0_ready = !reset && can_accept && grant0;
    req1_ready = !reset && can_accept && grant1;
    accept     = req0_ready || req1_ready;
    sel        = req1_ready;
    core_a     = sel ? req1_a  : req0_a;
    core_sh    = sel ? req1_sh : req0_sh;
    core_f     = sel ? req1_f  : req0_f;
  end

  shift_core #(.N(N)) u_core (
    .a  (core_a),
    .sh (core_sh),
    .f  (core_f),
    .y  (core_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid      <= 1'b0;
      res_y          <= '0;
      res_src        <= 1'b0;
      last_grant_reg <= 1'b1;
    end else if (accept) begin
      res_valid      <= 1'b1;
      res_y          <= core_y;
      res_src        <= sel;
      last_grant_reg <= sel;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter (N=3): directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a behavioural model.
module tb_shift_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a = '0, req1_a = '0;
  logic [2:0] req0_sh = '0, req1_sh = '0;
  logic [1:0] req0_f = '0, req1_f = '0;
  logic       res_valid, res_ready = 1'b0;
  logic [7:0] res_y;
  logic       res_src;

  int checks = 0;
  int failures = 0;

  // Behavioural model state (what the outputs must be after the next edge).
  logic       m_valid = 1'b0;
  logic [7:0] m_y = '0;
  logic       m_src = 1'b0;
  logic       m_last = 1'b1;

  shift_arbiter #(.N(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_sh    (req0_sh),
    .req0_f     (req0_f),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_sh    (req1_sh),
    .req1_f     (req1_f),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_y      (res_y),
    .res_src    (res_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] a, input int sh, input int f);
    int av = a;
    int r;
    case (f)
      0: r = (av << sh) & 255;
      1: r = av >> sh;
      3: begin
        r = av >> sh;
        if (a[7]) r = r | ((255 << (8 - sh)) & 255);
      end
      default: begin
`ifdef SHIFT_ROTATE_EN
        r = ((av << sh) | (av >> (8 - sh))) & 255;
`else
        r = av;
`endif
      end
    endcase
    return r[7:0];
  endfunction

  // Compare process: inputs are stable between negedge and the next posedge.
  always @(negedge clk) begin
    logic can, g0, g1, e0, e1;
    if (reset) begin
      check("rst_valid", res_valid, 0);
      check("rst_y", res_y, 0);
      check("rst_src", res_src, 0);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      m_valid = 1'b0; m_y = '0; m_src = 1'b0; m_last = 1'b1;
    end else begin
      check("res_valid", res_valid, m_valid);
      check("res_y", res_y, m_y);
      check("res_src", res_src, m_src);
      can = !m_valid || res_ready;
      if (req0_valid && req1_valid) begin
        g0 = m_last;
        g1 = !m_last;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
      e0 = can && g0;
      e1 = can && g1;
      check("req0_ready", req0_ready, e0);
      check("req1_ready", req1_ready, e1);
      $display("cyc t=%0t v0=%0b v1=%0b rr=%0b acc0=%0b acc1=%0b res_valid=%0b y=%02h src=%0b",
               $time, req0_valid, req1_valid, res_ready, e0, e1, res_valid, res_y, res_src);
      if (e0 || e1) begin
        m_valid = 1'b1;
        m_src   = e1;
        m_last  = e1;
        m_y     = e1 ? ref_shift(req1_a, req1_sh, req1_f) : ref_shift(req0_a, req0_sh, req0_f);
      end else if (res_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic drive(input logic v0, input logic [7:0] a0, input logic [2:0] s0, input logic [1:0] f0,
                       input logic v1, input logic [7:0] a1, input logic [2:0] s1, input logic [1:0] f1,
                       input logic rr);
    @(posedge clk);
    #2;
    req0_valid = v0; req0_a = a0; req0_sh = s0; req0_f = f0;
    req1_valid = v1; req1_a = a1; req1_sh = s1; req1_f = f1;
    res_ready = rr;
  endtask

  task automatic idle(input logic rr);
    drive(0, 8'h00, 3'd0, 2'd0, 0, 8'h00, 3'd0, 2'd0, rr);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
  endtask

  initial begin
    logic [7:0] rot_exp;
    // Reset state and hold after release
    repeat (2) @(posedge clk);
    #1;
    check("lit_rst_valid", res_valid, 0);
    check("lit_rst_y", res_y, 8'h00);
    idle(0);
    reset = 1'b0;
    idle(0);
    idle(0);
    check("lit_idle_valid", res_valid, 0);
    check("lit_idle_y", res_y, 8'h00);

    // Port 0 only: 0x96 SLL 3 -> 0xB0
    drive(1, 8'h96, 3'd3, 2'b00, 0, 8'h00, 3'd0, 2'd0, 1);
    #1 check("lit_sll_ready0", req0_ready, 1);
    idle(1);
    check("lit_sll_valid", res_valid, 1);
    check("lit_sll_y", res_y, 8'hB0);
    check("lit_sll_src", res_src, 0);
    idle(1);
    check("lit_consumed_valid", res_valid, 0);
    check("lit_consumed_hold_y", res_y, 8'hB0);

    // Contention after reset: port 0 first (SRA -> E5), then port 1 (SRL -> 4B)
    reset_pulse();
    drive(1, 8'h96, 3'd2, 2'b11, 1, 8'h96, 3'd1, 2'b01, 1);
    #1 check("lit_cont_ready0", req0_ready, 1);
    check("lit_cont_ready1", req1_ready, 0);
    drive(0, 8'h00, 3'd0, 2'd0, 1, 8'h96, 3'd1, 2'b01, 1);
    check("lit_cont_y0", res_y, 8'hE5);
    check("lit_cont_src0", res_src, 0);
    idle(1);
    check("lit_cont_y1", res_y, 8'h4B);
    check("lit_cont_src1", res_src, 1);
    idle(1);

    // Backpressure: result held for 3 cycles, then released with an accept the same cycle
    drive(1, 8'h5A, 3'd0, 2'b00, 0, 8'h00, 3'd0, 2'd0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'hFF, 3'd7, 2'b11, 1, 8'h3C, 3'd4, 2'b01, 0);
      #1;
      check("lit_stall_y", res_y, 8'h5A);
      check("lit_stall_valid", res_valid, 1);
      check("lit_stall_ready0", req0_ready, 0);
      check("lit_stall_ready1", req1_ready, 0);
    end
    res_ready = 1'b1;
    #1 check("lit_release_ready1", req1_ready, 1);
    idle(1);
    check("lit_release_y", res_y, 8'h03);
    check("lit_release_src", res_src, 1);
    idle(1);

    // Asynchronous reset while a result is held
    drive(1, 8'h81, 3'd1, 2'b00, 0, 8'h00, 3'd0, 2'd0, 0);
    idle(0);
    check("lit_held_y", res_y, 8'h02);
    #1 reset = 1'b1;
    #1 check("lit_async_valid", res_valid, 0);
    check("lit_async_y", res_y, 8'h00);
    drive(1, 8'h11, 3'd1, 2'b00, 1, 8'h22, 3'd1, 2'b00, 1);
    #1 check("lit_rst_noaccept1", req1_ready, 0);
    reset = 1'b0;
    #1 check("lit_post_ready0", req0_ready, 1);
    check("lit_post_ready1", req1_ready, 0);
    idle(1);
    check("lit_post_y", res_y, 8'h22);
    idle(1);

    // Op 10: rotate-left or pass-through depending on the build
`ifdef SHIFT_ROTATE_EN
    rot_exp = 8'h2D;
`else
    rot_exp = 8'h96;
`endif
    drive(1, 8'h96, 3'd1, 2'b10, 0, 8'h00, 3'd0, 2'd0, 1);
    idle(1);
    check("lit_op10_y", res_y, rot_exp);

    // Randomized traffic, with occasional asynchronous resets
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 1), 8'($urandom), 3'($urandom), 2'($urandom),
            $urandom_range(0, 1), 8'($urandom), 3'($urandom), 2'($urandom),
            ($urandom_range(0, 3) != 0));
      reset = ($urandom_range(0, 63) == 0);
    end
    reset = 1'b0;
    idle(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter N: default 3; log2 of data width (W = 2**N bits); shift amount width is N bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester k has a shift command pending.
REQ-005 req0_ready / req1_ready  output  1 each  command k accepted this cycle when valid and ready are both high.
REQ-006 req0_a / req1_a  input  W each  operand.
REQ-007 req0_sh / req1_sh  input  N each  shift amount, 0..W-1.
REQ-008 req0_f / req1_f  input  2 each  op: 00 SLL, 01 SRL, 10 PASS, 11 SRA.
REQ-009 res_valid  output  1  result register holds an unconsumed result.
REQ-010 res_ready  input  1  consumer accepts result when res_valid and res_ready are both high.
REQ-011 res_y  output  W  shifted result.
REQ-012 res_src  output  1  index of requester that produced res_y.

Function
REQ-013 One shared shift datapath; at most one command accepted per cycle.
REQ-014 can_accept = !res_valid || res_ready; reqk_ready = can_accept && granted to k; combinational, no dependence on reqk_ready of the other port.
REQ-015 Grant: only one valid -> that one; both valid -> port != last_grant; neither -> no grant.
REQ-016 last_grant updates only on an accepted command; otherwise it holds.
REQ-017 Latency: command accepted in cycle t -> res_valid=1 with res_y/res_src in cycle t+1.
REQ-018 Accept and consume in the same cycle -> result register reloaded, res_valid stays 1; back-to-back throughput 1 per cycle.
REQ-019 Consume without accept -> res_valid=0 next cycle; res_y/res_src hold their last values.
REQ-020 res_valid=1 and res_ready=0 -> res_y, res_src, res_valid stable; both reqk_ready=0.
REQ-021 Ops: SLL = a<<sh, SRL = a>>sh (zero fill), SRA = arithmetic right shift with sign fill from a[W-1], PASS = a; result truncated to W bits.
REQ-022 sh=0 -> res_y=a for all ops.

Reset
REQ-023 On reset asserted: res_valid=0, res_y=0, res_src=0, last_grant=1 so port 0 wins first contention; reqk_ready=0 while reset is high.
REQ-024 Reset mid-operation discards any held result; commands presented during reset are not accepted.

Configuration
REQ-025 Macro SHIFT_ROTATE_EN defined -> op 10 is rotate-left by sh (bits shifted out of a[W-1] re-enter at bit 0); undefined -> op 10 is PASS; all other behaviour identical.

Structure
REQ-026 Package shift_pkg holds the op enum (SLL, SRL, PASS_ROT, SRA), the default N, and a command struct {a, sh, f}.
REQ-027 One sub-module shift_core: combinational W-bit shifter (a, sh, f -> y) parameterised by N, instanced once; arbitration and result register stay in shift_arbiter.

Verification (N=3, W=8)
REQ-028 Reset -> res_valid=0, res_y=8'h00, res_src=0; after release with no requests, outputs hold.
REQ-029 Port 0 only: a=8'h96, sh=3, f=SLL -> next cycle res_valid=1, res_y=8'hB0, res_src=0.
REQ-030 Both valid after reset: p0 a=8'h96 sh=2 SRA; p1 a=8'h96 sh=1 SRL; res_ready=1 -> cycle t+1 res_y=8'hE5 src=0, cycle t+2 res_y=8'h4B src=1.
REQ-031 res_ready=0 for 3 cycles with a result held -> res_y unchanged, req0_ready=req1_ready=0; raise res_ready -> a new command is accepted that same cycle.
REQ-032 Assert reset while res_valid=1 -> res_valid=0 immediately (asynchronous); first command after release with both ports valid is granted to port 0.
REQ-033 a=8'h96, sh=1, f=10 -> res_y=8'h2D with SHIFT_ROTATE_EN, 8'h96 without.
